// File: rtl/red_arbiter.sv
// red_arbiter: two-requester round-robin front end for a shared
// GF(2) polynomial reduction unit, with timeout and grade checking.
module red_arbiter #(
  parameter int DATA_WIDTH = 4,
  parameter int TIMEOUT    = 2*DATA_WIDTH+8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req0_valid,
  output logic                          req0_ready,
  input  logic [2*DATA_WIDTH-1:0]       req0_poly,
  input  logic [$clog2(DATA_WIDTH):0]   req0_grade,
  input  logic [DATA_WIDTH:0]           req0_prim,
  input  logic                          req1_valid,
  output logic                          req1_ready,
  input  logic [2*DATA_WIDTH-1:0]       req1_poly,
  input  logic [$clog2(DATA_WIDTH):0]   req1_grade,
  input  logic [DATA_WIDTH:0]           req1_prim,
  output logic                          rsp0_valid,
  input  logic                          rsp0_ready,
  output logic                          rsp1_valid,
  input  logic                          rsp1_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          red_op_enable,
  output logic [$clog2(DATA_WIDTH):0]   red_grade,
  output logic [DATA_WIDTH:0]           red_prim,
  output logic [2*DATA_WIDTH-1:0]       red_poly,
  input  logic [DATA_WIDTH-1:0]         red_out,
  input  logic                          red_op_finish
);

  localparam int W  = DATA_WIDTH;
  localparam int GW = $clog2(W) + 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [GW-1:0] GMIN  = GW'(2);
  localparam logic [GW-1:0] GMAX  = GW'(W);
  localparam logic [CW-1:0] CLAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic            rr_q, rr_d;
  logic            own_q, own_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    data_q, data_d;
  logic            err_q, err_d;
  logic [2*W-1:0]  poly_q, poly_d;
  logic [GW-1:0]   grade_q, grade_d;
  logic [W:0]      prim_q, prim_d;

  logic            gnt0, gnt1;
  logic [2*W-1:0]  cap_poly;
  logic [GW-1:0]   cap_grade;
  logic [W:0]      cap_prim;
  logic            bad_grade;
  logic            own_ready;

  // Round-robin grant, only offered while idle and out of reset
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && state_q == S_IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt0 = !rr_q;
        gnt1 = rr_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign cap_poly  = gnt1 ? req1_poly  : req0_poly;
  assign cap_grade = gnt1 ? req1_grade : req0_grade;
  assign cap_prim  = gnt1 ? req1_prim  : req0_prim;
  assign bad_grade = (cap_grade < GMIN) || (cap_grade > GMAX);
  assign own_ready = own_q ? rsp1_ready : rsp0_ready;

  // Next-state and datapath update for the arbiter FSM
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    poly_d  = poly_q;
    grade_d = grade_q;
    prim_d  = prim_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt0 || gnt1) begin
          own_d   = gnt1;
          poly_d  = cap_poly;
          grade_d = cap_grade;
          prim_d  = cap_prim;
          if (bad_grade) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (red_op_finish) begin
          data_d  = red_out;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CLAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (own_ready) begin
          rr_d    = !own_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and capture registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      own_q   <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      poly_q  <= '0;
      grade_q <= '0;
      prim_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      poly_q  <= poly_d;
      grade_q <= grade_d;
      prim_q  <= prim_d;
    end
  end

  assign req0_ready    = gnt0;
  assign req1_ready    = gnt1;
  assign rsp0_valid    = rst_n && state_q == S_RESP && !own_q;
  assign rsp1_valid    = rst_n && state_q == S_RESP && own_q;
  assign red_op_enable = rst_n && state_q == S_RUN;
  assign rsp_data      = data_q;
  assign rsp_err       = err_q;
  assign red_poly      = poly_q;
  assign red_grade     = grade_q;
  assign red_prim      = prim_q;

endmodule

// File: tb/tb_red_arbiter.sv
// tb_red_arbiter: directed and random transactions against a
// round-robin / latency / GF(2) reduction reference model.
module tb_red_arbiter;

  localparam int W  = 4;
  localparam int TO = 2*W + 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready;
  logic [7:0] req0_poly;
  logic [2:0] req0_grade;
  logic [4:0] req0_prim;
  logic       req1_valid, req1_ready;
  logic [7:0] req1_poly;
  logic [2:0] req1_grade;
  logic [4:0] req1_prim;
  logic       rsp0_valid, rsp0_ready;
  logic       rsp1_valid, rsp1_ready;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic       red_op_enable;
  logic [2:0] red_grade;
  logic [4:0] red_prim;
  logic [7:0] red_poly;
  logic [3:0] red_out;
  logic       red_op_finish;

  int checks = 0;
  int errors = 0;

  int   fin_lat = 0;
  logic noise = 1'b0;
  int   ucnt = 0;
  logic pref = 1'b0;

  logic [7:0] op_poly [2];
  logic [2:0] op_grade[2];
  logic [4:0] op_prim [2];

  red_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_poly(req0_poly), .req0_grade(req0_grade),
    .req0_prim(req0_prim),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_poly(req1_poly), .req1_grade(req1_grade),
    .req1_prim(req1_prim),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .red_op_enable(red_op_enable),
    .red_grade(red_grade), .red_prim(red_prim),
    .red_poly(red_poly), .red_out(red_out),
    .red_op_finish(red_op_finish)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] gf_mod(
    input logic [7:0] p, input logic [4:0] m, input logic [2:0] g);
    logic [7:0] r;
    logic [7:0] mm;
    r  = p;
    mm = {3'b000, m};
    if (g < 2 || g > 4) return 4'h0;
    for (int i = 7; i >= 0; i--)
      if (i >= int'(g) && r[i]) r = r ^ (mm << (i - int'(g)));
    return r[3:0];
  endfunction

  // Model reduction unit: finishes after fin_lat enabled cycles
  always @(posedge clk)
    if (!red_op_enable) ucnt <= 0;
    else ucnt <= ucnt + 1;

  assign red_out = gf_mod(red_poly, red_prim, red_grade);
  assign red_op_finish =
    (red_op_enable && fin_lat > 0 && ucnt == fin_lat - 1) ||
    (!red_op_enable && noise);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_ops(input int k, input bit any_grade);
    logic [2:0] g;
    if (any_grade) g = 3'($urandom_range(0, 7));
    else g = 3'($urandom_range(2, 4));
    op_grade[k] = g;
    op_poly[k]  = 8'($urandom);
    if (g >= 2 && g <= 4)
      op_prim[k] = 5'((1 << g) | ($urandom & ((1 << g) - 1)) | 1);
    else
      op_prim[k] = 5'($urandom);
  endtask

  task automatic drive_ops();
    req0_poly = op_poly[0]; req0_grade = op_grade[0];
    req0_prim = op_prim[0];
    req1_poly = op_poly[1]; req1_grade = op_grade[1];
    req1_prim = op_prim[1];
  endtask

  task automatic txn(input logic [1:0] vm, input int lat,
                     input int hold);
    int w, en, waited, unstable, exp_run;
    bit bad;
    logic [3:0] ed, d0;
    logic ee, e0;
    w = (vm == 2'b11) ? int'(pref) : (vm[1] ? 1 : 0);
    fin_lat = lat;
    @(negedge clk);
    drive_ops();
    req0_valid = vm[0];
    req1_valid = vm[1];
    #1;
    chk("ready0", req0_ready, 32'(w == 0));
    chk("ready1", req1_ready, 32'(w == 1));
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    bad = op_grade[w] < 2 || op_grade[w] > 4;
    if (bad) begin
      ed = 4'h0; ee = 1'b1; exp_run = 0;
    end else if (lat > 0) begin
      ed = gf_mod(op_poly[w], op_prim[w], op_grade[w]);
      ee = 1'b0; exp_run = lat;
    end else begin
      ed = 4'h0; ee = 1'b1; exp_run = TO;
    end
    chk("load_en", red_op_enable, 0);
    chk("op_poly", red_poly, op_poly[w]);
    en = 0;
    waited = 0;
    while (!(rsp0_valid || rsp1_valid) && waited < TO + 8) begin
      if (red_op_enable) en++;
      @(negedge clk);
      waited++;
    end
    chk("run_cycles", en, exp_run);
    chk("latency", waited, bad ? 0 : exp_run + 1);
    chk("rsp_owner", {rsp1_valid, rsp0_valid}, w == 1 ? 2 : 1);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_err", rsp_err, ee);
    d0 = rsp_data;
    e0 = rsp_err;
    unstable = 0;
    if (hold > 0) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      if (w == 0) rsp1_ready = 1'b1;
      else rsp0_ready = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        #1;
        if (rsp_data !== d0 || rsp_err !== e0 ||
            req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
            {rsp1_valid, rsp0_valid} !== (w == 1 ? 2'b10 : 2'b01))
          unstable++;
      end
      chk("hold_stable", unstable, 0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = (w == 0);
    rsp1_ready = (w == 1);
    @(negedge clk);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    chk("rsp_done", {rsp1_valid, rsp0_valid}, 0);
    pref = !w[0];
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    for (int k = 0; k < 2; k++) rand_ops(k, 1'b0);
    drive_ops();
    repeat (3) @(negedge clk);
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    chk("rst_rspv", {rsp1_valid, rsp0_valid}, 0);
    chk("rst_en", red_op_enable, 0);
    chk("rst_data", {rsp_err, rsp_data}, 0);
    chk("rst_ops", {red_poly, red_grade, red_prim}, 0);
    rst_n = 1'b1;

    op_poly[0] = 8'b0100_0000;
    op_grade[0] = 3'd4;
    op_prim[0] = 5'b10011;
    txn(2'b01, 6, 0);
    chk("x6_mod", rsp_data_last(), 4'hC);

    for (int i = 0; i < 4; i++) begin
      rand_ops(0, 1'b0);
      rand_ops(1, 1'b0);
      txn(2'b11, $urandom_range(1, 6), 0);
    end

    rand_ops(1, 1'b0);
    op_grade[1] = 3'd1;
    txn(2'b10, 3, 0);

    rand_ops(0, 1'b0);
    txn(2'b01, 0, 0);

    rand_ops(1, 1'b0);
    txn(2'b10, 4, 10);

    noise = 1'b1;
    for (int i = 0; i < 14; i++) begin
      rand_ops(0, $urandom_range(0, 3) == 0);
      rand_ops(1, $urandom_range(0, 3) == 0);
      txn(2'($urandom_range(1, 3)),
          ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 8),
          $urandom_range(0, 3));
    end
    noise = 1'b0;

    rand_ops(0, 1'b0);
    txn(2'b01, 2, 0);
    rand_ops(0, 1'b0);
    fin_lat = 0;
    @(negedge clk);
    drive_ops();
    req0_valid = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_run", red_op_enable, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pref = 1'b0;
    chk("mid_rst_en", red_op_enable, 0);
    chk("mid_rst_rspv", {rsp1_valid, rsp0_valid}, 0);
    chk("mid_rst_rdy", {req1_ready, req0_ready}, 0);
    chk("mid_rst_data", {rsp_err, rsp_data}, 0);
    chk("mid_rst_ops", {red_poly, red_grade, red_prim}, 0);
    seen = 0;
    repeat (TO + 4) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid || red_op_enable) seen++;
    end
    chk("no_orphan_rsp", seen, 0);
    rand_ops(0, 1'b0);
    rand_ops(1, 1'b0);
    txn(2'b11, 3, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  function automatic logic [3:0] rsp_data_last();
    return gf_mod(8'b0100_0000, 5'b10011, 3'd4);
  endfunction

endmodule
